// File: rtl/imm_gen_stage.sv
// imm_gen_stage: decode-path immediate generator with a two-entry skid buffer.
// Each entry carries its registered immediate, tag and reserved-select flag.
module imm_gen_stage #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_imm_sel,
   input  logic [31:0]      in_inst,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_illegal,
   output logic [1:0]       count
);
   logic [31:0]      imm32;
   logic [XLEN-1:0]  new_imm;
   logic             new_ill;
   logic             m_v, s_v, m_ill, s_ill;
   logic [XLEN-1:0]  m_imm, s_imm;
   logic [TAG_W-1:0] m_tag, s_tag;
   logic             acc, drn, m_load;

   always_comb begin
      imm32 = '0;
      case (in_imm_sel)
         3'd0, 3'd5: imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
         3'd1: imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
         3'd2: imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
         3'd3: imm32 = {in_inst[31:12], 12'b0};
         3'd4: imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
         3'd6: imm32 = {27'b0, in_inst[19:15]};
         default: imm32 = '0;
      endcase
   end

   // Every format's sign lives in bit 31 of the 32-bit form (CSR and reserved are zero there).
   always_comb begin
      new_imm = {XLEN{imm32[31]}};
      new_imm[31:0] = imm32;
   end

   assign new_ill  = in_imm_sel == 3'd7;
   assign in_ready = !s_v;
   assign acc      = in_valid && in_ready && !flush;
   assign drn      = m_v && out_ready;
   assign m_load   = !m_v || drn;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_v   <= 1'b0;
         m_imm <= '0;
         m_tag <= '0;
         m_ill <= 1'b0;
         s_v   <= 1'b0;
         s_imm <= '0;
         s_tag <= '0;
         s_ill <= 1'b0;
      end else if (flush) begin
         m_v <= 1'b0;
         s_v <= 1'b0;
      end else begin
         if (m_load) begin
            m_v <= s_v || acc;
            if (s_v) begin
               m_imm <= s_imm;
               m_tag <= s_tag;
               m_ill <= s_ill;
            end else if (acc) begin
               m_imm <= new_imm;
               m_tag <= in_tag;
               m_ill <= new_ill;
            end
         end
         if (s_v && m_load) s_v <= 1'b0;
         else if (acc && !m_load) begin
            s_v   <= 1'b1;
            s_imm <= new_imm;
            s_tag <= in_tag;
            s_ill <= new_ill;
         end
      end
   end

   assign out_valid   = m_v;
   assign out_imm     = m_imm;
   assign out_tag     = m_tag;
   assign out_illegal = m_ill;
   assign count       = {1'b0, m_v} + {1'b0, s_v};
endmodule

// File: tb/tb_imm_gen_stage.sv
// tb_imm_gen_stage: directed checks of immediate formats, backpressure, flush and reset.
module tb_imm_gen_stage;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic [2:0]  in_imm_sel = '0;
   logic [31:0] in_inst = '0;
   logic [4:0]  in_tag = '0;
   logic        out_ready = 1'b1;
   logic        in_ready, out_valid, out_illegal;
   logic [31:0] out_imm;
   logic [4:0]  out_tag;
   logic [1:0]  count;
   logic        in_ready64, out_valid64, out_illegal64;
   logic [63:0] out_imm64;
   logic [4:0]  out_tag64;
   logic [1:0]  count64;
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   imm_gen_stage #(.XLEN(32), .TAG_W(5)) dut (
      .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_imm_sel(in_imm_sel), .in_inst(in_inst), .in_tag(in_tag), .out_valid(out_valid),
      .out_ready(out_ready), .out_imm(out_imm), .out_tag(out_tag), .out_illegal(out_illegal),
      .count(count)
   );

   imm_gen_stage #(.XLEN(64), .TAG_W(5)) dut64 (
      .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
      .in_imm_sel(in_imm_sel), .in_inst(in_inst), .in_tag(in_tag), .out_valid(out_valid64),
      .out_ready(out_ready), .out_imm(out_imm64), .out_tag(out_tag64), .out_illegal(out_illegal64),
      .count(count64)
   );

   logic [2:0]  v_sel  [10] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4, 3'd5, 3'd6, 3'd7};
   logic [31:0] v_inst [10] = '{32'hFFF00093, 32'h00A00223, 32'hFE000EE3, 32'h123450B7, 32'h80000037,
                                32'h0040006F, 32'hFFDFF06F, 32'h80000067, 32'h000F8073, 32'hFFFFFFFF};
   logic [31:0] v_e32  [10] = '{32'hFFFFFFFF, 32'h00000004, 32'hFFFFFFFC, 32'h12345000, 32'h80000000,
                                32'h00000004, 32'hFFFFFFFC, 32'hFFFFF800, 32'h0000001F, 32'h00000000};
   logic [63:0] v_e64  [10] = '{64'hFFFFFFFFFFFFFFFF, 64'h4, 64'hFFFFFFFFFFFFFFFC, 64'h12345000,
                                64'hFFFFFFFF80000000, 64'h4, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFF800,
                                64'h1F, 64'h0};

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      tick();
      tick();
      checks++;
      if (out_valid !== 1'b0 || count !== 2'd0 || in_ready !== 1'b1 || out_imm !== 32'h0 ||
          out_tag !== 5'h0 || out_illegal !== 1'b0) begin
         failures++;
         $display("FAIL reset_state got v=%b c=%0d r=%b imm=%h tag=%h ill=%b exp 0 0 1 0 0 0",
                  out_valid, count, in_ready, out_imm, out_tag, out_illegal);
      end
      @(negedge clk);
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_imm;
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         in_imm_sel = v_sel[i];
         in_inst = v_inst[i];
         in_tag = 5'(i + 1);
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_imm !== v_e32[i] || out_tag !== 5'(i + 1) ||
             out_illegal !== (v_sel[i] == 3'd7)) begin
            failures++;
            $display("FAIL imm32_vec%0d got v=%b imm=%h tag=%0d ill=%b exp imm=%h tag=%0d",
                     i, out_valid, out_imm, out_tag, out_illegal, v_e32[i], i + 1);
         end
         checks++;
         if (out_valid64 !== 1'b1 || out_imm64 !== v_e64[i] || out_illegal64 !== (v_sel[i] == 3'd7)) begin
            failures++;
            $display("FAIL imm64_vec%0d got v=%b imm=%h ill=%b exp %h", i, out_valid64, out_imm64,
                     out_illegal64, v_e64[i]);
         end
      end
      in_valid = 1'b0;
      tick();
      checks++;
      if (out_valid !== 1'b0 || count !== 2'd0) begin
         failures++;
         $display("FAIL imm_drain got v=%b c=%0d exp 0 0", out_valid, count);
      end
   endtask

   task automatic test_backpressure;
      int nt = 1, ne = 1, maxc = 0, gaps = 0, first = -1, last = 0, stalls = 0;
      bit rdy_low = 0, prev_stall = 0, acc;
      logic [4:0]  p_tag = '0;
      logic [31:0] p_imm = '0;
      for (int cyc = 0; cyc < 40 && ne <= 6; cyc++) begin
         out_ready = (cyc >= 3);
         in_valid = (nt <= 6);
         in_tag = 5'(nt);
         in_imm_sel = 3'd0;
         in_inst = {12'(nt * 3), 20'h00013};
         if (int'(count) > maxc) maxc = int'(count);
         if (!in_ready) rdy_low = 1;
         if (out_valid && out_ready) begin
            checks++;
            if (out_tag !== 5'(ne) || out_imm !== 32'(ne * 3)) begin
               failures++;
               $display("FAIL bp_order got tag=%0d imm=%h exp tag=%0d imm=%h", out_tag, out_imm, ne, ne * 3);
            end
            if (first < 0) first = cyc;
            else if (cyc != last + 1) gaps++;
            last = cyc;
            ne++;
         end
         if (out_valid && !out_ready) begin
            if (prev_stall) begin
               stalls++;
               checks++;
               if (out_tag !== p_tag || out_imm !== p_imm) begin
                  failures++;
                  $display("FAIL bp_stable got tag=%0d imm=%h exp tag=%0d imm=%h", out_tag, out_imm, p_tag, p_imm);
               end
            end
            prev_stall = 1;
            p_tag = out_tag;
            p_imm = out_imm;
         end else prev_stall = 0;
         acc = in_valid && in_ready;
         tick();
         if (acc) nt++;
      end
      in_valid = 1'b0;
      checks++;
      if (maxc != 2 || !rdy_low) begin
         failures++;
         $display("FAIL bp_full got maxcount=%0d ready_dropped=%0d exp 2 1", maxc, rdy_low);
      end
      checks++;
      if (ne != 7 || gaps != 0 || stalls == 0) begin
         failures++;
         $display("FAIL bp_complete got next_exp=%0d gaps=%0d stalls=%0d exp 7 0 >0", ne, gaps, stalls);
      end
      tick();
   endtask

   task automatic test_back_to_back;
      out_ready = 1'b1;
      in_imm_sel = 3'd6;
      for (int t = 20; t < 24; t++) begin
         in_valid = 1'b1;
         in_tag = 5'(t);
         in_inst = 32'(t) << 15;
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_tag !== 5'(t) || out_imm !== 32'(t) || count !== 2'd1) begin
            failures++;
            $display("FAIL b2b_tag%0d got v=%b tag=%0d imm=%h c=%0d exp 1 %0d %h 1",
                     t, out_valid, out_tag, out_imm, count, t, t);
         end
      end
      in_valid = 1'b0;
      tick();
      checks++;
      if (count !== 2'd0 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL b2b_drain got c=%0d v=%b exp 0 0", count, out_valid);
      end
   endtask

   task automatic test_flush;
      out_ready = 1'b0;
      in_imm_sel = 3'd0;
      in_inst = 32'h00100013;
      in_valid = 1'b1;
      in_tag = 5'd10;
      tick();
      in_tag = 5'd11;
      tick();
      checks++;
      if (count !== 2'd2 || in_ready !== 1'b0) begin
         failures++;
         $display("FAIL flush_fill got c=%0d r=%b exp 2 0", count, in_ready);
      end
      flush = 1'b1;
      in_tag = 5'd12;
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      checks++;
      if (count !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL flush_full got c=%0d v=%b r=%b exp 0 0 1", count, out_valid, in_ready);
      end
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_ghost got v=%b tag=%0d exp v=0", out_valid, out_tag);
         end
      end
      in_valid = 1'b1;
      in_tag = 5'd13;
      tick();
      in_tag = 5'd14;
      flush = 1'b1;
      checks++;
      if (out_valid !== 1'b1 || out_tag !== 5'd13) begin
         failures++;
         $display("FAIL flush_drain got v=%b tag=%0d exp 1 13", out_valid, out_tag);
      end
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      checks++;
      if (count !== 2'd0 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL flush_drop got c=%0d v=%b tag=%0d exp 0 0", count, out_valid, out_tag);
      end
   endtask

   task automatic test_async_reset;
      out_ready = 1'b0;
      in_imm_sel = 3'd0;
      in_inst = 32'hFFF00093;
      in_valid = 1'b1;
      in_tag = 5'd7;
      tick();
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || count !== 2'd0 || out_imm !== 32'h0 || out_imm64 !== 64'h0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL async_reset got v=%b c=%0d imm=%h imm64=%h r=%b exp 0 0 0 0 1",
                  out_valid, count, out_imm, out_imm64, in_ready);
      end
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      out_ready = 1'b1;
      in_valid = 1'b1;
      in_imm_sel = 3'd2;
      in_inst = 32'hFE000EE3;
      in_tag = 5'd9;
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_imm !== 32'hFFFFFFFC || out_tag !== 5'd9 || count !== 2'd1) begin
         failures++;
         $display("FAIL post_reset got v=%b imm=%h tag=%0d c=%0d exp 1 fffffffc 9 1",
                  out_valid, out_imm, out_tag, count);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_imm();
      test_backpressure();
      test_back_to_back();
      test_flush();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/imm_gen_stage.md
# imm_gen_stage

Pipelined, parametrised immediate-generation stage for the decode path. It accepts an instruction word plus an immediate-format select over a valid/ready handshake and produces the sign- or zero-extended immediate at XLEN width one cycle later. A two-entry skid buffer sustains full throughput under downstream backpressure. A synchronous flush discards in-flight entries on redirect; unsupported selects are flagged rather than silently zeroed.

## Interface
- XLEN, 32: immediate output width; legal values 32 or 64.
- TAG_W, 5: width of the sideband tag carried alongside each entry (e.g. rd or ROB index).
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous discard of all buffered entries.
- in_valid  input  1  upstream entry valid.
- in_ready  output  1  stage can accept an entry this cycle.
- in_imm_sel  input  3  immediate format select.
- in_inst  input  32  raw instruction word.
- in_tag  input  TAG_W  sideband tag.
- out_valid  output  1  out_imm/out_tag/out_illegal valid.
- out_ready  input  1  downstream accepts.
- out_imm  output  XLEN  generated immediate.
- out_tag  output  TAG_W  tag of the presented entry.
- out_illegal  output  1  presented entry used a reserved select.
- count  output  2  occupancy, 0..2.

## Operation
- Select encoding (fixed):
  - 0 = I: sext(inst[31:20]), sign bit always inst[31], for all opcodes including loads.
  - 1 = S: sext({inst[31:25], inst[11:7]}).
  - 2 = B: sext({inst[31], inst[7], inst[30:25], inst[11:8], 0}).
  - 3 = U: sext({inst[31:12], 12'b0}); at XLEN=64, bits 63:32 replicate inst[31].
  - 4 = JAL: sext({inst[31], inst[19:12], inst[20], inst[30:21], 0}).
  - 5 = JALR: identical to I.
  - 6 = CSR: zext(inst[19:15]).
  - 7 = reserved: imm = 0, out_illegal = 1.
- Sign extension always fills to XLEN.
- Immediate is computed combinationally from the input and registered with the entry; the output is never recomputed from a changing input.
- Storage is a main register (drives outputs) plus a skid register. Each holds {valid, imm, tag, illegal}.
- in_ready = !skid_valid. Accept = in_valid && in_ready && !flush.
- Drain = out_valid && out_ready.
- Main register update:
  - empty or draining: loads skid if skid valid, else the accepted entry, else becomes empty.
  - full and not draining: holds.
- Skid register update:
  - loads the accepted entry when main stays occupied and skid is empty.
  - clears when its contents move to main.
- Ordering is strictly FIFO.
- count = main_valid + skid_valid.
- Flush: next cycle both valids = 0 and count = 0. An accept offered in the flush cycle is dropped. A drain in the flush cycle completes normally downstream.

## Timing
- Reset values: out_valid=0, count=0, in_ready=1, out_imm=0, out_tag=0, out_illegal=0.
- Reset is asynchronous assert, synchronous release.
- Latency: entry accepted at edge N is presented from after edge N with empty pipe, i.e. visible in cycle N+1.
- Throughput: 1 entry/cycle with out_ready held high.
- in_ready depends only on registered state, with no combinational path from out_ready.
- out_* are stable while out_valid && !out_ready.
- Simultaneous accept and drain with count=1: main replaced, count stays 1.
- Simultaneous accept and drain with count=2: skid moves to main; in_ready was 0, so no accept.
- Reset mid-operation: all entries lost; outputs return to reset values immediately.

## Test plan
- Reset then I-type, in_inst=0xFFF00093, sel=0: out_imm=0xFFFFFFFF one cycle later (XLEN=32); 0xFFFFFFFFFFFFFFFF (XLEN=64); out_illegal=0.
- B and U: 0xFE000EE3/sel=2 -> 0xFFFFFFFC. 0x123450B7/sel=3 -> 0x12345000; at XLEN=64 0x80000037/sel=3 -> 0xFFFFFFFF80000000.
- CSR and reserved: inst with [19:15]=0x1F, sel=6 -> 0x0000001F. sel=7 -> out_imm=0, out_illegal=1.
- Backpressure: stream tags 1..6 with out_ready low for 3 cycles.
  - count reaches 2 and in_ready drops.
  - No tag lost or duplicated; output order 1..6.
  - Back-to-back output once out_ready rises.
- Flush with count=2 and in_valid high: next cycle count=0 and out_valid=0; the offered tag never appears.
- Assert reset_n low mid-stream: out_valid, count and out_imm are 0 immediately without a clock edge; normal operation resumes after release.
